// File: rtl/processador_parametrizado.sv
// processador_parametrizado
//    Small parametrised processor: register file of 2**ADDR_W words of WIDTH
//    bits, command interface with valid/ready handshake, and an 8-function ALU
//    with zero/carry/negative flags. MUL is a multi-cycle shift-add unit that
//    runs for WIDTH cycles.
//
// Ports
//    clock         single system clock, rising edge
//    reset         synchronous, active-high
//    cmd_valid     command present
//    cmd_ready     block can accept a command (IDLE and not in reset)
//    cmd_op        00 LOAD, 01 EXEC, 10 READ, 11 NOP
//    alu_op        ALU function for EXEC (111 = MUL)
//    addr_a/b/d    operand A (also READ source), operand B, destination
//    data_in       LOAD data
//    result        last EXEC/READ value
//    result_valid  one-cycle pulse when result updates
//    flag_zero/carry/neg  flags of the last EXEC
//    busy          inverse of cmd_ready
module processador_parametrizado #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [2:0]        alu_op,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  result,
   output logic              result_valid,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              flag_neg,
   output logic              busy
);

   localparam int NREGS = 2**ADDR_W;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_EXEC = 2'b01;
   localparam logic [1:0] OP_READ = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0]   regs [NREGS];
   logic [WIDTH-1:0]   op_a_reg, op_b_reg;
   logic [ADDR_W-1:0]  dst_reg;
   logic [2:0]         aluop_reg;
   logic               is_read_reg;
   logic [2*WIDTH-1:0] acc_reg, mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic               accept, mul_last, finish_any, finish_alu;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_r;
   logic               alu_c;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [WIDTH-1:0]   wr_data;

   assign cmd_ready = (state_reg == S_IDLE) && !reset;
   assign busy      = ~cmd_ready;
   assign accept    = cmd_valid && cmd_ready;

   // One shift-add step; on the last MUL edge this is already the full product.
   assign acc_step   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign mul_last   = (state_reg == S_MUL) && (cnt_reg == CNT_LAST);
   assign finish_any = (state_reg == S_EXEC) || mul_last;
   assign finish_alu = ((state_reg == S_EXEC) && !is_read_reg) || mul_last;

   // ALU on the captured operands.
   always_comb begin
      sum   = '0;
      alu_r = '0;
      alu_c = 1'b0;
      case (aluop_reg)
         3'b000: begin
            sum   = {1'b0, op_a_reg} + {1'b0, op_b_reg};
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
         end
         3'b001: begin
            // carry set means no borrow
            sum   = {1'b0, op_a_reg} + {1'b0, ~op_b_reg} + (WIDTH+1)'(1);
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
         end
         3'b010: alu_r = op_a_reg & op_b_reg;
         3'b011: alu_r = op_a_reg | op_b_reg;
         3'b100: alu_r = op_a_reg ^ op_b_reg;
         3'b101: begin
            alu_r = {op_a_reg[WIDTH-2:0], 1'b0};
            alu_c = op_a_reg[WIDTH-1];
         end
         3'b110: begin
            alu_r = {1'b0, op_a_reg[WIDTH-1:1]};
            alu_c = op_a_reg[0];
         end
         default: begin
            alu_r = acc_step[WIDTH-1:0];
            alu_c = |acc_step[2*WIDTH-1:WIDTH];
         end
      endcase
   end

   // Single write port: LOAD only happens in IDLE, writeback only outside IDLE,
   // so the two sources never collide.
   always_comb begin
      wr_en   = (accept && (cmd_op == OP_LOAD)) || finish_alu;
      wr_addr = finish_alu ? dst_reg : addr_d;
      wr_data = finish_alu ? alu_r : data_in;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_regs
         always_ff @(posedge clock) begin
            if (reset)
               regs[gi] <= '0;
            else if (wr_en && (wr_addr == ADDR_W'(gi)))
               regs[gi] <= wr_data;
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept && (cmd_op == OP_READ))
               state_next = S_EXEC;
            else if (accept && (cmd_op == OP_EXEC))
               state_next = (alu_op == 3'b111) ? S_MUL : S_EXEC;
         end
         S_EXEC:  state_next = S_IDLE;
         S_MUL:   if (cnt_reg == CNT_LAST) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         result       <= '0;
         result_valid <= 1'b0;
         flag_zero    <= 1'b0;
         flag_carry   <= 1'b0;
         flag_neg     <= 1'b0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         dst_reg      <= '0;
         aluop_reg    <= '0;
         is_read_reg  <= 1'b0;
         acc_reg      <= '0;
         mcand_reg    <= '0;
         mplier_reg   <= '0;
         cnt_reg      <= '0;
      end else begin
         result_valid <= 1'b0;
         // Operands are captured at accept, so addr_d may alias a source.
         if (accept && ((cmd_op == OP_READ) || (cmd_op == OP_EXEC))) begin
            op_a_reg    <= regs[addr_a];
            op_b_reg    <= regs[addr_b];
            dst_reg     <= addr_d;
            aluop_reg   <= alu_op;
            is_read_reg <= (cmd_op == OP_READ);
            acc_reg     <= '0;
            mcand_reg   <= {{WIDTH{1'b0}}, regs[addr_a]};
            mplier_reg  <= regs[addr_b];
            cnt_reg     <= '0;
         end
         if (state_reg == S_MUL) begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
         end
         if (finish_any) begin
            result       <= is_read_reg ? op_a_reg : alu_r;
            result_valid <= 1'b1;
            if (!is_read_reg) begin
               flag_zero  <= (alu_r == '0);
               flag_carry <= alu_c;
               flag_neg   <= alu_r[WIDTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_processador_parametrizado.sv
// Testbench for processador_parametrizado: directed scenarios with literal
// expectations followed by randomized commands, all checked every cycle
// against a latency-based behavioural model of the processor.
module tb_processador_parametrizado;

   localparam int W  = 8;
   localparam int AW = 2;
   localparam int NR = 2**AW;

   logic          clock = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [2:0]    alu_op;
   logic [AW-1:0] addr_a, addr_b, addr_d;
   logic [W-1:0]  data_in;
   logic [W-1:0]  result;
   logic          result_valid, flag_zero, flag_carry, flag_neg, busy;

   int checks   = 0;
   int failures = 0;

   processador_parametrizado #(.WIDTH(W), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .alu_op(alu_op), .addr_a(addr_a), .addr_b(addr_b),
      .addr_d(addr_d), .data_in(data_in), .result(result),
      .result_valid(result_valid), .flag_zero(flag_zero),
      .flag_carry(flag_carry), .flag_neg(flag_neg), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A command occupies the block for a fixed number of edges (1, or W for MUL);
   // its outcome is computed arithmetically at accept and published when the
   // latency runs out.
   longint m_regs [NR];
   longint m_res;
   bit     m_z, m_c, m_n, m_valid;
   int     m_busy;
   longint p_r;
   bit     p_c, p_read;
   int     p_d;

   function automatic void alu_model(input int op, input longint a, input longint b,
                                     output longint r, output bit c);
      longint m, s;
      m = longint'(1) << W;
      c = 1'b0;
      case (op)
         0: begin s = a + b;           r = s % m; c = (s >= m); end
         1: begin s = a + (m - 1 - b) + 1; r = s % m; c = (s >= m); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = (a * 2) % m; c = (a >= m / 2); end
         6: begin r = a / 2; c = (a % 2) == 1; end
         default: begin s = a * b; r = s % m; c = (s >= m); end
      endcase
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NR; i++) m_regs[i] = 0;
         m_res = 0; m_z = 0; m_c = 0; m_n = 0; m_valid = 0; m_busy = 0;
      end else begin
         m_valid = 0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_res   = p_r;
               m_valid = 1;
               if (!p_read) begin
                  m_regs[p_d] = p_r;
                  m_z = (p_r == 0);
                  m_n = (p_r >= (longint'(1) << (W - 1)));
                  m_c = p_c;
               end
            end
         end else if (cmd_valid) begin
            case (cmd_op)
               2'b00: m_regs[addr_d] = longint'(data_in);
               2'b10: begin p_read = 1; p_r = m_regs[addr_a]; m_busy = 1; end
               2'b01: begin
                  p_read = 0;
                  p_d    = int'(addr_d);
                  alu_model(int'(alu_op), m_regs[addr_a], m_regs[addr_b], p_r, p_c);
                  m_busy = (alu_op == 3'b111) ? W : 1;
               end
               default: ;
            endcase
         end
      end
      #1;
      chk("cmd_ready",    cmd_ready,    (m_busy == 0) && !reset);
      chk("busy",         busy,         !((m_busy == 0) && !reset));
      chk("result_valid", result_valid, m_valid);
      chk("result",       result,       m_res);
      chk("flag_zero",    flag_zero,    m_z);
      chk("flag_carry",   flag_carry,   m_c);
      chk("flag_neg",     flag_neg,     m_n);
   end

   // ---------------- directed helpers ----------------
   task automatic issue(input logic [1:0] op, input logic [2:0] aop, input int a,
                        input int b, input int d, input logic [W-1:0] din);
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op    = op;
      alu_op    = aop;
      addr_a    = AW'(a);
      addr_b    = AW'(b);
      addr_d    = AW'(d);
      data_in   = din;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      while (1) begin
         @(posedge clock);
         #1;
         n++;
         if (result_valid) break;
         if (n >= maxc) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: no result_valid after %0d cycles", n);
            break;
         end
      end
   endtask

   task automatic load(input int d, input logic [W-1:0] v);
      issue(2'b00, 3'b000, 0, 0, d, v);
   endtask

   task automatic exec_chk(input string name, input logic [2:0] aop, input int a,
                           input int b, input int d, input int lat,
                           input logic [W-1:0] er, input bit ez, input bit ec, input bit en);
      int n;
      issue(2'b01, aop, a, b, d, '0);
      wait_valid(lat + 2, n);
      chk({name, " latency"}, n, lat);
      chk({name, " result"},  result, er);
      chk({name, " zero"},    flag_zero, ez);
      chk({name, " carry"},   flag_carry, ec);
      chk({name, " neg"},     flag_neg, en);
      $display("txn %s: result=%0h z=%0b c=%0b n=%0b", name, result, flag_zero, flag_carry, flag_neg);
   endtask

   task automatic read_chk(input string name, input int a, input logic [W-1:0] er);
      int n;
      issue(2'b10, 3'b000, a, 0, 0, '0);
      wait_valid(3, n);
      chk({name, " latency"}, n, 1);
      chk({name, " result"},  result, er);
      $display("txn %s: r%0d=%0h", name, a, result);
   endtask

   initial begin
      int n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; alu_op = '0;
      addr_a = '0; addr_b = '0; addr_d = '0; data_in = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("reset cmd_ready", cmd_ready, 1);
      chk("reset result", result, 0);

      // 1: ADD with negative result, single-cycle pulse, READ keeps flags
      load(0, 8'h7F);
      load(1, 8'h01);
      exec_chk("add", 3'b000, 0, 1, 2, 1, 8'h80, 0, 0, 1);
      @(posedge clock); #1;
      chk("add pulse width", result_valid, 0);
      read_chk("read r2", 2, 8'h80);
      chk("read keeps neg", flag_neg, 1);

      // 2: SUB with borrow, SUB to zero
      exec_chk("sub borrow", 3'b001, 1, 0, 2, 1, 8'h82, 0, 0, 1);
      load(3, 8'hFF);
      exec_chk("sub zero", 3'b001, 3, 3, 2, 1, 8'h00, 1, 1, 0);

      // 3: MUL with overflow, LOAD during MUL ignored
      load(0, 8'h10);
      load(1, 8'h11);
      issue(2'b01, 3'b111, 0, 1, 2, '0);
      load(0, 8'hAA);
      wait_valid(10, n);
      chk("mul remaining latency", n, W - 2);
      chk("mul result", result, 8'h10);
      chk("mul carry", flag_carry, 1);
      $display("txn mul: result=%0h c=%0b", result, flag_carry);
      read_chk("read r0 after mul", 0, 8'h10);

      // 4: shifts and AND
      load(0, 8'h81);
      exec_chk("shl", 3'b101, 0, 0, 2, 1, 8'h02, 0, 1, 0);
      exec_chk("shr", 3'b110, 0, 0, 2, 1, 8'h40, 0, 1, 0);
      load(0, 8'hF0);
      load(1, 8'h0F);
      exec_chk("and", 3'b010, 0, 1, 2, 1, 8'h00, 1, 0, 0);

      // 5: back-to-back, second command issued in the valid cycle
      load(0, 8'h05);
      load(1, 8'h03);
      exec_chk("add b2b 1", 3'b000, 0, 1, 0, 1, 8'h08, 0, 0, 0);
      exec_chk("add b2b 2", 3'b000, 0, 1, 0, 1, 8'h0B, 0, 0, 0);

      // 6: reset at the 4th MUL edge aborts everything
      issue(2'b01, 3'b111, 0, 1, 2, '0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("ready low in reset", cmd_ready, 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (12) @(negedge clock);
      for (int i = 0; i < NR; i++) read_chk("read after reset", i, 8'h00);
      chk("flags after reset", {flag_zero, flag_carry, flag_neg}, 0);

      // Randomized commands, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         reset     = ($urandom_range(0, 199) == 0);
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = 2'($urandom_range(0, 3));
         alu_op    = 3'($urandom_range(0, 7));
         addr_a    = AW'($urandom_range(0, NR - 1));
         addr_b    = AW'($urandom_range(0, NR - 1));
         addr_d    = AW'($urandom_range(0, NR - 1));
         data_in   = W'($urandom);
      end
      @(negedge clock);
      reset = 1'b0; cmd_valid = 1'b0;
      repeat (W + 2) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
